// File: rtl/gfx_write_queue_if.sv
// Host-side write bus of the graphics write queue.
// The host (master) presents one write per cycle that wr_valid is high;
// the queue (slave) reports wr_ready whenever it still has room.
interface gfx_write_queue_if #(
  parameter int ADDR_W = 16,
  parameter int DATA_W = 16
);
  logic              wr_valid;
  logic [ADDR_W-1:0] wr_addr;
  logic [DATA_W-1:0] wr_data;
  logic              wr_ready;

  modport master (output wr_valid, output wr_addr, output wr_data, input wr_ready);
  modport slave  (input wr_valid, input wr_addr, input wr_data, output wr_ready);
endinterface

// File: rtl/gfx_write_queue.sv
// Graphics write queue: buffers host writes in a FIFO and replays them, one
// at a time and in order, to one of NT targets selected by the address MSBs.
// Each issued write is held until the target reports gfx_done or the wait
// times out, then the chip selects drop for at least one cycle.
module gfx_write_queue #(
  parameter int ADDR_W   = 16,
  parameter int DATA_W   = 16,
  parameter int DEPTH    = 8,
  parameter int SEL_BITS = 1,
  parameter int TIMEOUT  = 255,
  localparam int NT      = 2 ** SEL_BITS,
  localparam int LVL_W   = $clog2(DEPTH) + 1,
  localparam int GA_W    = ADDR_W - SEL_BITS
) (
  input  logic               clk,
  input  logic               reset,
  gfx_write_queue_if.slave   host,
  output logic               almost_full,
  output logic [LVL_W-1:0]   level,
  output logic [7:0]         drop_count,
  output logic [7:0]         timeout_count,
  output logic [NT-1:0]      gfx_cs,
  output logic [GA_W-1:0]    gfx_addr,
  output logic [DATA_W-1:0]  gfx_data,
  input  logic               gfx_done,
  input  logic               gfx_write_avail
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam logic [15:0]      WAIT_LAST = 16'(TIMEOUT - 1);
  localparam logic [LVL_W-1:0] LVL_FULL  = LVL_W'(DEPTH);
  localparam logic [LVL_W-1:0] LVL_AFULL = LVL_W'(DEPTH - 1);

  typedef enum logic [1:0] {IDLE, ACTIVE, RELEASE} state_t;

  logic [ADDR_W-1:0] mem_addr [DEPTH];
  logic [DATA_W-1:0] mem_data [DEPTH];

  logic [PTR_W-1:0]  head_reg, tail_reg;
  logic [LVL_W-1:0]  level_reg;
  logic [7:0]        drop_reg, timeout_reg;
  logic [15:0]       wait_reg;
  state_t            state_reg;
  logic [NT-1:0]     cs_reg;
  logic [GA_W-1:0]   addr_reg;
  logic [DATA_W-1:0] data_reg;

  logic              push, pop, full;
  logic [ADDR_W-1:0] head_addr;
  logic [SEL_BITS-1:0] head_sel;

  // Fullness is judged on the current level, so a pop at full never makes
  // room for a push in the same cycle.
  assign full          = (level_reg == LVL_FULL);
  assign host.wr_ready = !full;
  assign push          = host.wr_valid && !full;
  assign pop           = (state_reg == RELEASE);
  assign head_addr     = mem_addr[head_reg];
  assign head_sel      = head_addr[ADDR_W-1 -: SEL_BITS];

  assign almost_full   = (level_reg >= LVL_AFULL);
  assign level         = level_reg;
  assign drop_count    = drop_reg;
  assign timeout_count = timeout_reg;
  assign gfx_cs        = cs_reg;
  assign gfx_addr      = addr_reg;
  assign gfx_data      = data_reg;

  // Queue storage: written at the tail, no reset so it maps onto RAM.
  always_ff @(posedge clk) begin
    if (push) begin
      mem_addr[tail_reg] <= host.wr_addr;
      mem_data[tail_reg] <= host.wr_data;
    end
  end

  // Tail pointer, occupancy and refused-write counter.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      tail_reg  <= '0;
      level_reg <= '0;
      drop_reg  <= '0;
    end else begin
      if (push) tail_reg <= tail_reg + 1'b1;
      level_reg <= level_reg + LVL_W'(push) - LVL_W'(pop);
      if (host.wr_valid && full && drop_reg != 8'hFF) drop_reg <= drop_reg + 8'd1;
    end
  end

  // Issue FSM: load head entry, hold it until done/timeout, then pop.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_reg   <= IDLE;
      head_reg    <= '0;
      wait_reg    <= '0;
      cs_reg      <= '0;
      addr_reg    <= '0;
      data_reg    <= '0;
      timeout_reg <= '0;
    end else begin
      case (state_reg)
        IDLE: begin
          cs_reg <= '0;
          if (level_reg != '0 && gfx_write_avail) begin
            cs_reg    <= NT'(1) << head_sel;
            addr_reg  <= head_addr[GA_W-1:0];
            data_reg  <= mem_data[head_reg];
            wait_reg  <= '0;
            state_reg <= ACTIVE;
          end
        end
        ACTIVE: begin
          wait_reg <= wait_reg + 16'd1;
          if (gfx_done) begin
            cs_reg    <= '0;
            state_reg <= RELEASE;
          end else if (wait_reg == WAIT_LAST) begin
            cs_reg    <= '0;
            state_reg <= RELEASE;
            if (timeout_reg != 8'hFF) timeout_reg <= timeout_reg + 8'd1;
          end
        end
        RELEASE: begin
          cs_reg    <= '0;
          head_reg  <= head_reg + 1'b1;
          state_reg <= IDLE;
        end
        default: begin
          cs_reg    <= '0;
          state_reg <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: doc/gfx_write_queue.md
GFX_WRITE_QUEUE -- requirements
Module: gfx_write_queue

Interface
REQ-001 SHALL have parameter ADDR_W, default 16, host write address width (word address).
REQ-002 SHALL have parameter DATA_W, default 16, write data width.
REQ-003 SHALL have parameter DEPTH, default 8, queue entries; power of two, >= 2.
REQ-004 SHALL have parameter SEL_BITS, default 1, address MSBs selecting target; NT = 2**SEL_BITS targets.
REQ-005 SHALL have parameter TIMEOUT, default 255, max cycles waiting for gfx_done; 1..65535.
REQ-006 SHALL have port clk  in  1  sole clock; all logic on posedge clk.
REQ-007 SHALL have port reset  in  1  asynchronous, active-low reset (0 = in reset).
REQ-008 SHALL have port wr_valid  in  1  host write request, one entry per high cycle.
REQ-009 SHALL have port wr_addr  in  ADDR_W  host write address.
REQ-010 SHALL have port wr_data  in  DATA_W  host write data.
REQ-011 SHALL have port wr_ready  out  1  queue not full (combinational from level).
REQ-012 SHALL have port almost_full  out  1  level >= DEPTH-1.
REQ-013 SHALL have port level  out  clog2(DEPTH)+1  entries currently queued.
REQ-014 SHALL have port drop_count  out  8  saturating count of writes refused while full.
REQ-015 SHALL have port timeout_count  out  8  saturating count of aborted writes.
REQ-016 SHALL have port gfx_cs  out  NT  one-hot target chip select, registered.
REQ-017 SHALL have port gfx_addr  out  ADDR_W-SEL_BITS  target address (wr_addr low bits), registered.
REQ-018 SHALL have port gfx_data  out  DATA_W  target write data, registered.
REQ-019 SHALL have port gfx_done  in  1  target signals write completed.
REQ-020 SHALL have port gfx_write_avail  in  1  target can accept a write without stalling.

Function
REQ-021 SHALL store {wr_addr, wr_data} at tail when wr_valid && wr_ready on a clock edge; level +1.
REQ-022 SHALL refuse wr_valid while !wr_ready, leave queue unchanged, increment drop_count, saturating at 255.
REQ-023 SHALL, on same-cycle push and pop, keep level unchanged; pop at full does not admit that cycle's push (wr_ready is evaluated before the pop).
REQ-024 SHALL wrap head/tail pointers modulo DEPTH; never exceed DEPTH entries or pop when empty.
REQ-025 SHALL implement FSM states IDLE, ACTIVE, RELEASE.
REQ-026 IDLE: if level != 0 and gfx_write_avail == 1 -> load head entry into gfx_addr/gfx_data, set gfx_cs bit = wr_addr[ADDR_W-1 -: SEL_BITS], clear wait counter, -> ACTIVE; else stay, gfx_cs = 0.
REQ-027 ACTIVE: hold gfx_cs/gfx_addr/gfx_data stable; count cycles; on gfx_done == 1 -> RELEASE.
REQ-028 ACTIVE: when wait counter reaches TIMEOUT with gfx_done low -> increment timeout_count (saturating 255), -> RELEASE.
REQ-029 RELEASE: gfx_cs = 0, pop head entry (exactly one pop per issued write, timed-out or not), -> IDLE.
REQ-030 SHALL hold gfx_cs at 0 for at least one cycle between consecutive writes.
REQ-031 Latency: push at edge N into an empty queue with gfx_write_avail high -> gfx_cs high after edge N+1.
REQ-032 gfx_write_avail SHALL be sampled only in IDLE; deassertion during ACTIVE does not abort.
REQ-033 gfx_done seen in IDLE or RELEASE SHALL be ignored.
REQ-034 Entries SHALL issue in strict FIFO order regardless of target.

Reset
REQ-035 On reset low, immediately: level 0, pointers 0, FSM IDLE, gfx_cs 0, gfx_addr 0, gfx_data 0, drop_count 0, timeout_count 0, wait counter 0.
REQ-036 Reset asserted mid-ACTIVE SHALL drop in-flight and queued entries; no gfx_cs pulse after release.
REQ-037 After reset release, wr_ready = 1, almost_full = 0 on first edge.

Verification
REQ-038 Defaults; push addr 0x0012 data 0xBEEF, avail 1, done one cycle after cs -> gfx_cs 2'b01, gfx_addr 0x0012, gfx_data 0xBEEF, one cycle low gap, level returns 0.
REQ-039 Push 0x8005/0x1234 -> gfx_cs 2'b10, gfx_addr 0x0005.
REQ-040 avail 0, push 9 writes -> level 8, wr_ready 0, almost_full 1 at level 7, drop_count 1; set avail 1, done each cycle -> 8 writes issued in push order.
REQ-041 TIMEOUT=4, gfx_done held 0 -> gfx_cs high exactly 4 cycles then 0, timeout_count 1, next entry issues.
REQ-042 Reset low during ACTIVE with 3 entries queued -> gfx_cs 0 immediately, level 0, no further cs after reset high.
REQ-043 Push and pop in same cycle at level 3 -> level stays 3; 300 refused pushes -> drop_count 255.
